// File: rtl/host_input_queue_pkg.sv
// Shared field widths, descriptor layout and FSM encodings for the host input queue.
package host_input_queue_pkg;

    localparam int TSNTAG_W = 48;
    localparam int BUFID_W  = 9;
    localparam int FLAG_W   = 1;
    localparam int DESC_W   = TSNTAG_W + BUFID_W + FLAG_W;

    typedef struct packed {
        logic [TSNTAG_W-1:0] tsntag;
        logic [BUFID_W-1:0]  bufid;
        logic [FLAG_W-1:0]   flag;
    } desc_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } out_state_e;

    typedef enum logic {
        REL_IDLE = 1'b0,
        REL_WAIT = 1'b1
    } rel_state_e;

endpackage

// File: rtl/host_input_queue_sync_fifo.sv
// Synchronous FIFO with same-cycle push/pop; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module hiq_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       iv_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       ov_rdata,
    output logic                   o_push_ok,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] ov_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, pop_ok;

    assign o_empty   = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop_ok    = i_pop && !o_empty;
    assign o_push_ok = i_push && (!full || pop_ok);
    assign ov_rdata  = mem_q[rd_ptr_q];
    assign ov_count  = count_q;

    always_comb begin
        count_d = count_q;
        case ({o_push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers are power-of-two wide so they wrap on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (o_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)    rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (o_push_ok) mem_q[wr_ptr_q] <= iv_wdata;
    end

endmodule

// File: rtl/host_input_queue.sv
// Host input queue: buffers descriptors for the host transmit process and hands
// discarded buffer ids back to the PCB. Define HIQ_DEBUG_CNT_EN for debug counters.
module host_input_queue
    import host_input_queue_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int REL_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [TSNTAG_W-1:0]    iv_tsntag,
    input  logic [BUFID_W-1:0]     iv_bufid,
    input  logic                   i_inverse_map_lookup_flag,
    input  logic                   i_descriptor_wr,
    output logic [TSNTAG_W-1:0]    ov_tsntag_network,
    output logic [BUFID_W-1:0]     ov_bufid_network,
    output logic                   o_inverse_map_lookup_flag_network,
    output logic                   o_descriptor_wr_network,
    input  logic                   i_descriptor_ack_network,
    output logic [BUFID_W-1:0]     ov_pkt_bufid,
    output logic                   o_pkt_bufid_wr,
    input  logic                   i_pkt_bufid_ack,
    output logic                   o_host_inqueue_discard_pulse,
    output logic                   o_release_overflow_pulse,
    output logic [$clog2(DEPTH):0] ov_queue_depth
`ifdef HIQ_DEBUG_CNT_EN
    ,
    output logic [15:0]            ov_enqueue_cnt,
    output logic [15:0]            ov_discard_cnt,
    output logic [$clog2(DEPTH):0] ov_max_depth
`endif
);

    desc_t                     wr_desc, head_desc, desc_q;
    logic                      desc_pop, desc_push_ok, desc_empty;
    logic [$clog2(DEPTH):0]    desc_count;
    logic                      discard_d, discard_q, rel_ovf_q;
    logic                      rel_pop, rel_push_ok, rel_empty;
    logic [BUFID_W-1:0]        rel_head, rel_bufid_q;
    logic [$clog2(REL_DEPTH):0] unused_rel_count;
    out_state_e                state_q;
    rel_state_e                rel_state_q;
    logic                      desc_wr_q, rel_wr_q;

    assign wr_desc   = '{tsntag: iv_tsntag, bufid: iv_bufid, flag: i_inverse_map_lookup_flag};
    assign discard_d = i_descriptor_wr && !desc_push_ok;
    assign desc_pop  = (state_q == IDLE) && !desc_empty;
    assign rel_pop   = (rel_state_q == REL_IDLE) && !rel_empty;

    hiq_sync_fifo #(.WIDTH(DESC_W), .DEPTH(DEPTH)) u_desc_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (i_descriptor_wr),
        .iv_wdata  (wr_desc),
        .i_pop     (desc_pop),
        .ov_rdata  (head_desc),
        .o_push_ok (desc_push_ok),
        .o_empty   (desc_empty),
        .ov_count  (desc_count)
    );

    hiq_sync_fifo #(.WIDTH(BUFID_W), .DEPTH(REL_DEPTH)) u_rel_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (discard_d),
        .iv_wdata  (iv_bufid),
        .i_pop     (rel_pop),
        .ov_rdata  (rel_head),
        .o_push_ok (rel_push_ok),
        .o_empty   (rel_empty),
        .ov_count  (unused_rel_count)
    );

    // Descriptor hand-off: the head is latched and held until the host acks it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            desc_q    <= '0;
            desc_wr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!desc_empty) begin
                    desc_q    <= head_desc;
                    desc_wr_q <= 1'b1;
                    state_q   <= WAIT_ACK;
                end
                WAIT_ACK: if (i_descriptor_ack_network) begin
                    desc_wr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rel_state_q <= REL_IDLE;
            rel_bufid_q <= '0;
            rel_wr_q    <= 1'b0;
        end else begin
            case (rel_state_q)
                REL_IDLE: if (!rel_empty) begin
                    rel_bufid_q <= rel_head;
                    rel_wr_q    <= 1'b1;
                    rel_state_q <= REL_WAIT;
                end
                REL_WAIT: if (i_pkt_bufid_ack) begin
                    rel_wr_q    <= 1'b0;
                    rel_state_q <= REL_IDLE;
                end
                default: rel_state_q <= REL_IDLE;
            endcase
        end
    end

    // Overflow is flagged alongside the discard whose bufid found no release slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            discard_q <= 1'b0;
            rel_ovf_q <= 1'b0;
        end else begin
            discard_q <= discard_d;
            rel_ovf_q <= discard_d && !rel_push_ok;
        end
    end

    assign ov_tsntag_network                 = desc_q.tsntag;
    assign ov_bufid_network                  = desc_q.bufid;
    assign o_inverse_map_lookup_flag_network = desc_q.flag[0];
    assign o_descriptor_wr_network           = desc_wr_q;
    assign ov_pkt_bufid                      = rel_bufid_q;
    assign o_pkt_bufid_wr                    = rel_wr_q;
    assign o_host_inqueue_discard_pulse      = discard_q;
    assign o_release_overflow_pulse          = rel_ovf_q;
    assign ov_queue_depth                    = desc_count;

`ifdef HIQ_DEBUG_CNT_EN
    logic [15:0]            enq_cnt_q, disc_cnt_q;
    logic [$clog2(DEPTH):0] max_depth_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            enq_cnt_q   <= '0;
            disc_cnt_q  <= '0;
            max_depth_q <= '0;
        end else begin
            if (desc_push_ok)             enq_cnt_q   <= enq_cnt_q + 16'd1;
            if (discard_d)                disc_cnt_q  <= disc_cnt_q + 16'd1;
            if (desc_count > max_depth_q) max_depth_q <= desc_count;
        end
    end

    assign ov_enqueue_cnt = enq_cnt_q;
    assign ov_discard_cnt = disc_cnt_q;
    assign ov_max_depth   = max_depth_q;
`endif

endmodule

// File: tb/tb_host_input_queue.sv
// Directed bench for host_input_queue (DEPTH=16, REL_DEPTH=4); one task per scenario.
module tb_host_input_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] tsn = '0;
    logic [8:0]  bid = '0;
    logic        flg = 1'b0;
    logic        wr = 1'b0;
    logic        dack = 1'b0;
    logic        pack = 1'b0;
    logic [47:0] otsn;
    logic [8:0]  obid, pbid;
    logic        oflg, dwr, pwr, disc, ovf;
    logic [4:0]  depth;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    host_input_queue #(.DEPTH(16), .REL_DEPTH(4)) dut (
        .i_clk                             (clk),
        .i_rst                             (rst),
        .iv_tsntag                         (tsn),
        .iv_bufid                          (bid),
        .i_inverse_map_lookup_flag         (flg),
        .i_descriptor_wr                   (wr),
        .ov_tsntag_network                 (otsn),
        .ov_bufid_network                  (obid),
        .o_inverse_map_lookup_flag_network (oflg),
        .o_descriptor_wr_network           (dwr),
        .i_descriptor_ack_network          (dack),
        .ov_pkt_bufid                      (pbid),
        .o_pkt_bufid_wr                    (pwr),
        .i_pkt_bufid_ack                   (pack),
        .o_host_inqueue_discard_pulse      (disc),
        .o_release_overflow_pulse          (ovf),
        .ov_queue_depth                    (depth)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if ({dwr, pwr, disc, ovf} !== 4'b0) $display("FAIL reset_strobes got %b exp 0000", {dwr, pwr, disc, ovf});
        else n_pass++;
        n_chk++;
        if (depth !== 5'd0) $display("FAIL reset_depth got %0d exp 0", depth);
        else n_pass++;
        n_chk++;
        if ({otsn, obid, oflg, pbid} !== 67'd0) $display("FAIL reset_data got %h exp 0", {otsn, obid, oflg, pbid});
        else n_pass++;
    endtask

    task automatic test_single();
        for (int k = 0; k < 7; k++) tick();
        tsn = 48'h0102_0304_0506; bid = 9'h1A; flg = 1'b1; wr = 1'b1;
        tick();
        wr = 1'b0;
        n_chk++;
        if ({dwr, depth} !== {1'b0, 5'd1}) $display("FAIL single_n1 got wr=%0b depth=%0d exp wr=0 depth=1", dwr, depth);
        else n_pass++;
        tick();
        n_chk++;
        if ({dwr, otsn, obid, oflg, depth} !== {1'b1, 48'h0102_0304_0506, 9'h1A, 1'b1, 5'd0})
            $display("FAIL single_n2 got wr=%0b tsn=%h bid=%h flag=%0b depth=%0d exp 1/010203040506/01a/1/0", dwr, otsn, obid, oflg, depth);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if ({dwr, otsn, obid} !== {1'b1, 48'h0102_0304_0506, 9'h1A})
                $display("FAIL single_hold got wr=%0b tsn=%h bid=%h exp 1/010203040506/01a", dwr, otsn, obid);
            else n_pass++;
        end
        dack = 1'b1;
        tick();
        dack = 1'b0;
        n_chk++;
        if (dwr !== 1'b0) $display("FAIL single_ack_drop got %0b exp 0", dwr);
        else n_pass++;
        // Ack arriving while the FSM is idle (popping) must not cancel the next descriptor.
        tsn = 48'h0A0B_0C0D_0E0F; bid = 9'h02B; flg = 1'b0; wr = 1'b1;
        tick();
        wr = 1'b0; dack = 1'b1;
        tick();
        dack = 1'b0;
        n_chk++;
        if ({dwr, obid} !== {1'b1, 9'h02B}) $display("FAIL idle_ack_ignored got wr=%0b bid=%h exp 1/02b", dwr, obid);
        else n_pass++;
        tick();
        n_chk++;
        if (dwr !== 1'b1) $display("FAIL idle_ack_hold got %0b exp 1", dwr);
        else n_pass++;
        dack = 1'b1;
        tick();
        dack = 1'b0;
        tick();
    endtask

    // 17 writes: the first is popped to the output, 16 fill the queue; the 18th is discarded.
    task automatic test_full();
        int bad = 0;
        for (int i = 0; i < 17; i++) begin
            tsn = 48'hA000 + 48'(i); bid = 9'(9'h100 + i); flg = 1'b0; wr = 1'b1;
            tick();
            if (disc !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL full_no_discard got %0d pulses exp 0", bad);
        else n_pass++;
        n_chk++;
        if ({depth, dwr, otsn} !== {5'd16, 1'b1, 48'hA000})
            $display("FAIL full_depth got depth=%0d wr=%0b tsn=%h exp 16/1/a000", depth, dwr, otsn);
        else n_pass++;
        tsn = 48'hAFFF; bid = 9'h1FF;
        tick();
        wr = 1'b0;
        n_chk++;
        if ({disc, ovf, depth} !== {1'b1, 1'b0, 5'd16})
            $display("FAIL full_discard got disc=%0b ovf=%0b depth=%0d exp 1/0/16", disc, ovf, depth);
        else n_pass++;
        tick();
        n_chk++;
        if ({disc, pwr, pbid} !== {1'b0, 1'b1, 9'h1FF})
            $display("FAIL full_release got disc=%0b pwr=%0b pbid=%h exp 0/1/1ff", disc, pwr, pbid);
        else n_pass++;
    endtask

    // Ack frees the output; the pop in the following idle cycle makes room for a write in that cycle.
    task automatic test_full_ack();
        dack = 1'b1;
        tick();
        dack = 1'b0;
        tsn = 48'hB000; bid = 9'h0AB; wr = 1'b1;
        n_chk++;
        if ({dwr, depth} !== {1'b0, 5'd16}) $display("FAIL fullack_pop_cycle got wr=%0b depth=%0d exp 0/16", dwr, depth);
        else n_pass++;
        tick();
        wr = 1'b0;
        n_chk++;
        if ({disc, depth, dwr, otsn} !== {1'b0, 5'd16, 1'b1, 48'hA001})
            $display("FAIL fullack_accept got disc=%0b depth=%0d wr=%0b tsn=%h exp 0/16/1/a001", disc, depth, dwr, otsn);
        else n_pass++;
    endtask

    // Release output still holds 1FF unacked, so four discards fill the release FIFO and the fifth overflows.
    task automatic test_overflow();
        logic [8:0] exp_b [5] = '{9'h1FF, 9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4};
        for (int i = 0; i < 5; i++) begin
            tsn = 48'hC000 + 48'(i); bid = 9'(9'h0C1 + i); wr = 1'b1;
            tick();
            if (i == 4) wr = 1'b0;
            n_chk++;
            if ({disc, ovf} !== {1'b1, (i == 4)})
                $display("FAIL ovf_pulse%0d got disc=%0b ovf=%0b exp 1/%0b", i, disc, ovf, (i == 4));
            else n_pass++;
        end
        for (int j = 0; j < 5; j++) begin
            n_chk++;
            if ({pwr, pbid} !== {1'b1, exp_b[j]}) $display("FAIL rel_order%0d got pwr=%0b pbid=%h exp 1/%h", j, pwr, pbid, exp_b[j]);
            else n_pass++;
            pack = 1'b1;
            tick();
            pack = 1'b0;
            n_chk++;
            if (pwr !== 1'b0) $display("FAIL rel_drop%0d got %0b exp 0", j, pwr);
            else n_pass++;
            tick();
        end
        n_chk++;
        if (pwr !== 1'b0) $display("FAIL rel_overflowed_dropped got %0b exp 0", pwr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tsn = 48'hD000 + 48'(i); bid = 9'(9'h050 + i); flg = 1'b1; wr = 1'b1;
            tick();
        end
        wr = 1'b0;
        n_chk++;
        if ({depth, dwr} !== {5'd5, 1'b1}) $display("FAIL rstmid_pre got depth=%0d wr=%0b exp 5/1", depth, dwr);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({dwr, pwr, disc, ovf, depth, otsn, obid, oflg, pbid} !== 76'd0)
            $display("FAIL rstmid_clear got wr=%0b depth=%0d tsn=%h bid=%h exp all 0", dwr, depth, otsn, obid);
        else n_pass++;
        dack = 1'b1;
        tick();
        dack = 1'b0;
        n_chk++;
        if ({dwr, depth} !== {1'b0, 5'd0}) $display("FAIL rstmid_ack got wr=%0b depth=%0d exp 0/0", dwr, depth);
        else n_pass++;
        tick();
        n_chk++;
        if (dwr !== 1'b0) $display("FAIL rstmid_idle got %0b exp 0", dwr);
        else n_pass++;
    endtask

    // One write per cycle with ack held high drains one descriptor per two cycles.
    // The queue reaches 16 at cycle 31, so writes 32, 34, 36 and 38 are discarded.
    task automatic test_stream();
        int exp_q[$];
        int got = 0;
        int ndisc = 0;
        int e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++)
            if (!(i >= 32 && (i % 2) == 0)) exp_q.push_back(i);
        dack = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (t < 40) begin
                tsn = 48'hC0DE_0000_0000 + 48'(t); bid = 9'(t); flg = t[0]; wr = 1'b1;
            end else begin
                wr = 1'b0;
            end
            tick();
            if (disc === 1'b1) ndisc++;
            if (dwr === 1'b1) begin
                got++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra got bid=%h exp none", obid);
                end else begin
                    e = exp_q.pop_front();
                    if ({otsn, obid, oflg} !== {48'hC0DE_0000_0000 + 48'(e), 9'(e), e[0]})
                        $display("FAIL stream_order got tsn=%h bid=%h flag=%0b exp index %0d", otsn, obid, oflg, e);
                    else n_pass++;
                end
            end
        end
        dack = 1'b0;
        wr = 1'b0;
        n_chk++;
        if (got != 36) $display("FAIL stream_count got %0d exp 36", got);
        else n_pass++;
        n_chk++;
        if (ndisc != 4) $display("FAIL stream_discards got %0d exp 4", ndisc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_ack();
        test_overflow();
        test_reset_mid();
        test_stream();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
